// File: rtl/ram_responder.sv
// ram_responder: word-organised RAM slave with a request/ready handshake,
// configurable access latency, byte-lane writes and an LR/SC reservation.
// One access is in flight at a time. Request fields are captured when the
// request leaves RAM_IDLE. rdata/err are meaningful only while ready=1.
module ram_responder #(
  parameter int unsigned WORDS   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ren,
  input  logic        wen,
  input  logic        lr,
  input  logic        sc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  strobe,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  typedef logic [1:0] ram_state_t;

  localparam ram_state_t RAM_IDLE = 2'd0;
  localparam ram_state_t RAM_WAIT = 2'd1;
  localparam ram_state_t RAM_DONE = 2'd2;

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]  LAT   = LATENCY[3:0];

  ram_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request fields captured on leaving RAM_IDLE
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  strobe_q;
  logic        lr_q;
  logic        sc_q;
  logic        wr_q;

  // LR/SC reservation
  logic        resv_valid_q;
  logic [29:0] resv_idx_q;

  logic [31:0] mem [WORDS];

  logic             accept;
  logic             done;
  logic             in_range;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      cur_word;
  logic             resv_hit;
  logic             do_write;
  logic             unused_addr_bits;

  // Byte offset is irrelevant for a word-organised memory.
  assign unused_addr_bits = ^addr[1:0];

  assign accept   = (state_q == RAM_IDLE) && (ren || wen);
  assign done     = (state_q == RAM_DONE);
  assign in_range = ({2'b00, idx_q} < WORDS);
  assign mem_idx  = idx_q[IDX_W-1:0];
  assign cur_word = mem[mem_idx];
  assign resv_hit = resv_valid_q && (resv_idx_q == idx_q);

  // Plain writes always land when in range; SC only with a matching reservation.
  assign do_write = done && wr_q && in_range && (!sc_q || resv_hit);

  // Next-state logic for the control FSM and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RAM_IDLE: begin
        if (ren || wen) begin
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? RAM_DONE : RAM_WAIT;
        end
      end
      RAM_WAIT: begin
        if (!ren && !wen) begin
          // Initiator withdrew the request: abandon silently.
          state_d = RAM_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          // Counter reaches zero on this edge, so ready follows next cycle.
          state_d = RAM_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RAM_DONE: begin
        state_d = RAM_IDLE;
      end
      default: begin
        state_d = RAM_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= RAM_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture request fields; they stay frozen until the next acceptance
  always_ff @(posedge clk) begin
    if (nrst && accept) begin
      idx_q    <= addr[31:2];
      wdata_q  <= wdata;
      strobe_q <= strobe;
      lr_q     <= lr;
      sc_q     <= sc;
      wr_q     <= wen;
    end
  end

  // Reservation tracking: set by LR, cleared by any SC or a plain write to it
  always_ff @(posedge clk) begin
    if (!nrst) begin
      resv_valid_q <= 1'b0;
      resv_idx_q   <= 30'd0;
    end else if (done && in_range) begin
      if (!wr_q && lr_q) begin
        resv_valid_q <= 1'b1;
        resv_idx_q   <= idx_q;
      end else if (wr_q && sc_q) begin
        resv_valid_q <= 1'b0;
      end else if (wr_q && resv_hit) begin
        resv_valid_q <= 1'b0;
      end
    end
  end

  // Byte-lane memory write; contents are not reset, and a reset edge blocks it
  always_ff @(posedge clk) begin
    if (nrst && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe_q[i]) begin
          mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Response outputs, driven only in RAM_DONE
  always_comb begin
    ready = done;
    err   = done && !in_range;
    rdata = 32'd0;
    if (done) begin
      if (wr_q && sc_q) begin
        // SC status: 0 = stored, 1 = failed (out-of-range SC also fails).
        rdata = (in_range && resv_hit) ? 32'd0 : 32'd1;
      end else if (in_range) begin
        // Reads and plain writes both return the pre-access word.
        rdata = cur_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (WORDS=4096, LATENCY=2).
module tb_ram_responder;

  logic        clk;
  logic        nrst;
  logic        ren;
  logic        wen;
  logic        lr;
  logic        sc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  ram_responder #(
    .WORDS  (4096),
    .LATENCY(2)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .ren   (ren),
    .wen   (wen),
    .lr    (lr),
    .sc    (sc),
    .addr  (addr),
    .wdata (wdata),
    .strobe(strobe),
    .rdata (rdata),
    .ready (ready),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge. Spends one idle cycle so the DUT is in
  // RAM_IDLE, then holds the request until ready (bounded).
  task automatic do_req(input logic r, input logic w, input logic l, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                        output logic [31:0] rd_o, output logic er_o, output int cyc);
    logic seen;
    @(posedge clk); #1;
    ren = r; wen = w; lr = l; sc = s; addr = a; wdata = d; strobe = st;
    cyc  = 0;
    seen = 1'b0;
    rd_o = 32'd0;
    er_o = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin
        seen = 1'b1;
        rd_o = rdata;
        er_o = err;
      end
    end
    ren = 1'b0; wen = 1'b0; lr = 1'b0; sc = 1'b0;
    if (!seen) check("ready_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] r; logic e; int c;
    do_req(1'b0, 1'b1, 1'b0, 1'b0, a, d, st, r, e, c);
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r; logic e; int c;
    do_req(1'b1, 1'b0, 1'b0, 1'b0, a, 32'd0, 4'd0, r, e, c);
    check(tag, r, exp);
  endtask

  task automatic lr_op(input logic [31:0] a);
    logic [31:0] r; logic e; int c;
    do_req(1'b1, 1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0, r, e, c);
  endtask

  task automatic sc_exp(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
    logic [31:0] r; logic e; int c;
    do_req(1'b0, 1'b1, 1'b0, 1'b1, a, d, 4'hF, r, e, c);
    check(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          c;
    int          hits;

    nrst = 1'b0; ren = 1'b0; wen = 1'b0; lr = 1'b0; sc = 1'b0;
    addr = 32'd0; wdata = 32'd0; strobe = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    nrst = 1'b1;

    // Full-word write then read, with latency LATENCY+1 = 3
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, r, e, c);
    check("wr_latency", c, 32'd3);
    check("wr_err", {31'd0, e}, 32'd0);
    do_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 4'd0, r, e, c);
    check("rd_latency", c, 32'd3);
    check("rd_data", r, 32'hDEADBEEF);
    check("rd_err", {31'd0, e}, 32'd0);

    // Byte-lane merge
    wr(32'h20, 32'h11223344, 4'hF);
    wr(32'h20, 32'h0000AA00, 4'b0010);
    rd_exp("strobe_merge", 32'h20, 32'h1122AA44);

    // ren and wen together: write wins, rdata is the pre-write word
    do_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'hFFFFFFFF, 4'b0001, r, e, c);
    check("rw_prewrite", r, 32'h1122AA44);
    rd_exp("rw_written", 32'h20, 32'h1122AAFF);

    // strobe=0000 completes without changing memory
    wr(32'h10, 32'h0, 4'h0);
    rd_exp("strobe_zero", 32'h10, 32'hDEADBEEF);

    // LR/SC success, then a second SC fails without writing
    wr(32'h40, 32'h0, 4'hF);
    lr_op(32'h40);
    sc_exp("sc_ok", 32'h40, 32'd5, 32'd0);
    rd_exp("sc_ok_data", 32'h40, 32'd5);
    sc_exp("sc_again", 32'h40, 32'd9, 32'd1);
    rd_exp("sc_again_data", 32'h40, 32'd5);

    // Plain write to the reserved word breaks the reservation
    lr_op(32'h40);
    wr(32'h40, 32'd7, 4'hF);
    sc_exp("sc_broken", 32'h40, 32'd8, 32'd1);
    rd_exp("sc_broken_data", 32'h40, 32'd7);

    // Write elsewhere keeps it
    lr_op(32'h40);
    wr(32'h44, 32'd3, 4'hF);
    sc_exp("sc_other", 32'h40, 32'd6, 32'd0);
    rd_exp("sc_other_data", 32'h40, 32'd6);

    // Out of range (index 4096 would alias word 0 if not guarded)
    wr(32'h0, 32'hCAFEF00D, 4'hF);
    do_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h4000, 32'd0, 4'd0, r, e, c);
    check("oor_rd_err", {31'd0, e}, 32'd1);
    check("oor_rd_data", r, 32'd0);
    do_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h4000, 32'h12345678, 4'hF, r, e, c);
    check("oor_wr_err", {31'd0, e}, 32'd1);
    rd_exp("oor_no_alias", 32'h0, 32'hCAFEF00D);

    // Abort: drop ren while waiting
    @(posedge clk); #1;
    ren = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    ren = 1'b0;
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    check("abort_no_ready", hits, 32'd0);
    do_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 4'd0, r, e, c);
    check("after_abort_latency", c, 32'd3);
    check("after_abort_data", r, 32'hDEADBEEF);

    // Reset in the wait phase of a write, with a live reservation
    lr_op(32'h40);
    @(posedge clk); #1;
    wen = 1'b1; addr = 32'h40; wdata = 32'hBAD; strobe = 4'hF;
    @(posedge clk); #1;
    hits = ready ? 1 : 0;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    wen  = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    check("rst_no_ready", hits, 32'd0);
    rd_exp("rst_mem_kept", 32'h40, 32'd6);
    sc_exp("rst_resv_clr", 32'h40, 32'd1, 32'd1);
    rd_exp("rst_sc_nowrite", 32'h40, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
